// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiply datapath and its control.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        WAIT_ACK = 2'd2,
        DONE     = 2'd3
    } drain_state_t;

    // Bus-word depth of the result shift lane; the drain controller's credit pool matches it.
    localparam int DRAIN_BUFFERS_DEF = 4;

    function automatic int word_elems(input int bus_w, input int data_w);
        return bus_w / data_w;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/drain_credit_cnt.sv
// Tracks free bus-word slots in the result lane; flags a return with nothing outstanding.
module drain_credit_cnt
    import matmul_pkg::*;
#(
    parameter int BUFFERS = DRAIN_BUFFERS_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       consume_i,
    input  logic                       return_i,
    output logic [$clog2(BUFFERS):0]   credits_o,
    output logic                       full_o,
    output logic                       err_o
);

    localparam int CW = $clog2(BUFFERS) + 1;

    logic [CW-1:0] credits_q, credits_d;
    logic          err_q, err_d;
    logic          full;

    assign full = (credits_q == CW'(BUFFERS));

    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        case ({consume_i, return_i})
            2'b10: begin
                if (credits_q != '0) begin
                    credits_d = credits_q - CW'(1);
                end
            end
            2'b01: begin
                if (full) begin
                    err_d = 1'b1;
                end else begin
                    credits_d = credits_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            credits_q <= CW'(BUFFERS);
            err_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    assign credits_o = credits_q;
    assign full_o    = full;
    assign err_o     = err_q;

endmodule

// File: rtl/result_drain_ctrl.sv
// Drains the systolic array into the result lane one element per cycle, credit-limited.
//
// state    | meaning
// IDLE     | waiting for start_i
// DRAIN    | emitting elements (row, col); stalls when a new word has no credit
// WAIT_ACK | all elements emitted, waiting for every lane word to be accepted
// DONE     | one-cycle done_o pulse, then IDLE
module result_drain_ctrl
    import matmul_pkg::*;
#(
    parameter int ARRAY_WIDTH  = 4,
    parameter int ARRAY_HEIGHT = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int BUS_WIDTH    = 256,
    parameter int BUFFERS      = DRAIN_BUFFERS_DEF
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start_i,
    input  logic                              accepted_i,
    output logic                              array_reset_n [ARRAY_WIDTH-1:0],
    output logic [cnt_w(ARRAY_HEIGHT)-1:0]    row_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              err_o
);

    localparam int WORD_ELEMS = word_elems(BUS_WIDTH, DATA_WIDTH);
    localparam int TOTAL      = ARRAY_WIDTH * ARRAY_HEIGHT;
    localparam int COL_W      = cnt_w(ARRAY_WIDTH);
    localparam int ROW_W      = cnt_w(ARRAY_HEIGHT);
    localparam int E_W        = cnt_w(WORD_ELEMS);
    localparam int CW         = $clog2(BUFFERS) + 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(ARRAY_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ARRAY_HEIGHT - 1);
    localparam logic [E_W-1:0]   E_LAST   = E_W'(WORD_ELEMS - 1);

    if (TOTAL % WORD_ELEMS != 0) begin : g_bad_total
        $error("result_drain_ctrl: array element count must fill whole bus words");
    end
    if ((BUFFERS < 2) || ((BUFFERS & (BUFFERS - 1)) != 0)) begin : g_bad_buffers
        $error("result_drain_ctrl: BUFFERS must be a power of two and at least 2");
    end

    drain_state_t     state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [E_W-1:0]   e_cnt_q, e_cnt_d;
    logic [ARRAY_WIDTH-1:0] arn_q, arn_d;
    logic [ROW_W-1:0] row_out_q, row_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    logic [E_W-1:0]   cur_e;
    logic             try_emit;
    logic             consume;
    logic             credit_avail;
    logic [CW-1:0]    credits;
    logic             credits_full;
    logic             credit_err;

    drain_credit_cnt #(
        .BUFFERS (BUFFERS)
    ) u_credit (
        .clk       (clk),
        .reset_n   (reset_n),
        .consume_i (consume),
        .return_i  (accepted_i),
        .credits_o (credits),
        .full_o    (credits_full),
        .err_o     (credit_err)
    );

    // A word accepted this cycle is already spendable on the emission registered at this edge.
    assign credit_avail = (credits != '0) || accepted_i;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        e_cnt_d   = e_cnt_q;
        arn_d     = '1;
        row_out_d = row_out_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        consume   = 1'b0;
        try_emit  = 1'b0;
        cur_col   = col_q;
        cur_row   = row_q;
        cur_e     = e_cnt_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = DRAIN;
                    busy_d   = 1'b1;
                    cur_col  = '0;
                    cur_row  = '0;
                    cur_e    = '0;
                    try_emit = 1'b1;
                end
            end
            DRAIN: begin
                try_emit = 1'b1;
            end
            WAIT_ACK: begin
                if (credits_full) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (try_emit) begin
            col_d   = cur_col;
            row_d   = cur_row;
            e_cnt_d = cur_e;
            if ((cur_e != '0) || credit_avail) begin
                consume          = (cur_e == '0);
                arn_d[cur_col]   = 1'b0;
                row_out_d        = cur_row;
                e_cnt_d          = (cur_e == E_LAST) ? '0 : cur_e + E_W'(1);
                if (cur_col == COL_LAST) begin
                    col_d = '0;
                    if (cur_row == ROW_LAST) begin
                        row_d   = '0;
                        state_d = WAIT_ACK;
                    end else begin
                        row_d = cur_row + ROW_W'(1);
                    end
                end else begin
                    col_d = cur_col + COL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            e_cnt_q   <= '0;
            arn_q     <= '1;
            row_out_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            e_cnt_q   <= e_cnt_d;
            arn_q     <= arn_d;
            row_out_q <= row_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    for (genvar c = 0; c < ARRAY_WIDTH; c++) begin : g_col
        assign array_reset_n[c] = arn_q[c];
    end

    assign row_o  = row_out_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = credit_err;

endmodule

// File: tb/tb_result_drain_ctrl.sv
// Directed bench for result_drain_ctrl: 4x4 array, 4 elements per word, 4 and 2 lane buffers.
module tb_result_drain_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start1, acc1, start2, acc2;
    logic       arn1_u [3:0];
    logic       arn2_u [3:0];
    logic [1:0] row1, row2;
    logic       busy1, done1, err1;
    logic       busy2, done2, err2;
    logic [3:0] arn1, arn2;

    assign arn1 = {arn1_u[3], arn1_u[2], arn1_u[1], arn1_u[0]};
    assign arn2 = {arn2_u[3], arn2_u[2], arn2_u[1], arn2_u[0]};

    int checks   = 0;
    int failures = 0;

    result_drain_ctrl #(
        .ARRAY_WIDTH (4), .ARRAY_HEIGHT (4), .DATA_WIDTH (16), .BUS_WIDTH (64), .BUFFERS (4)
    ) dut1 (
        .clk (clk), .reset_n (reset_n), .start_i (start1), .accepted_i (acc1),
        .array_reset_n (arn1_u), .row_o (row1), .busy_o (busy1), .done_o (done1), .err_o (err1)
    );

    result_drain_ctrl #(
        .ARRAY_WIDTH (4), .ARRAY_HEIGHT (4), .DATA_WIDTH (16), .BUS_WIDTH (64), .BUFFERS (2)
    ) dut2 (
        .clk (clk), .reset_n (reset_n), .start_i (start2), .accepted_i (acc2),
        .array_reset_n (arn2_u), .row_o (row2), .busy_o (busy2), .done_o (done2), .err_o (err2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] col_mask(input int c);
        logic [3:0] m;
        m    = 4'hF;
        m[c] = 1'b0;
        return m;
    endfunction

    // Cycle 0 is the start cycle; emission k is visible in cycle k+1.
    task automatic drain1(input string tag, input int n, input int acc_k, input int restart_k);
        for (int k = 0; k < n; k++) begin
            start1 = (k == 0) || (k == restart_k);
            acc1   = (k == acc_k);
            step();
            chk({tag, "_arn"}, 32'(arn1), 32'(col_mask(k % 4)));
            chk({tag, "_row"}, 32'(row1), 32'(k / 4));
            chk({tag, "_busy"}, 32'(busy1), 32'd1);
        end
        start1 = 1'b0;
        acc1   = 1'b0;
    endtask

    // Called in the last-emission cycle; n accepts there and after, done two cycles past the last.
    task automatic wait_done1(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            acc1 = 1'b1;
            step();
            chk({tag, "_wait_arn"}, 32'(arn1), 32'hF);
            chk({tag, "_wait_done"}, 32'(done1), 32'd0);
        end
        acc1 = 1'b0;
        chk({tag, "_pre_done"}, 32'(done1), 32'd0);
        chk({tag, "_pre_busy"}, 32'(busy1), 32'd1);
        step();
        chk({tag, "_done"}, 32'(done1), 32'd1);
        chk({tag, "_done_busy"}, 32'(busy1), 32'd0);
        step();
        chk({tag, "_post_done"}, 32'(done1), 32'd0);
        chk({tag, "_post_busy"}, 32'(busy1), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        start1  = 1'b0;
        acc1    = 1'b0;
        start2  = 1'b0;
        acc2    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arn", 32'(arn1), 32'hF);
        chk("rst_row", 32'(row1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_err", 32'(err1), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("idle_arn", 32'(arn1), 32'hF);
        chk("idle_busy", 32'(busy1), 32'd0);

        // Two-buffer instance: 8 emissions, stall, accept in cycle 20 resumes at (2,0) in cycle 21.
        for (int k = 0; k <= 20; k++) begin
            start2 = (k == 0);
            acc2   = (k == 20);
            step();
            if (k + 1 <= 8) begin
                chk("stall_pre_arn", 32'(arn2), 32'(col_mask(k % 4)));
                chk("stall_pre_row", 32'(row2), 32'(k / 4));
            end else if (k + 1 <= 20) begin
                chk("stall_arn", 32'(arn2), 32'hF);
                chk("stall_busy", 32'(busy2), 32'd1);
            end else begin
                chk("stall_resume_arn", 32'(arn2), 32'(col_mask(0)));
                chk("stall_resume_row", 32'(row2), 32'd2);
            end
        end
        start2 = 1'b0;
        acc2   = 1'b0;
        chk("stall_err", 32'(err2), 32'd0);
        chk("stall_done", 32'(done2), 32'd0);

        // Basic drain, then a back-to-back drain with an accept on the cycle word 3 takes its credit.
        drain1("basic", 16, -1, -1);
        wait_done1("basic", 4);
        drain1("simul", 16, 8, -1);
        wait_done1("simul", 3);
        chk("simul_err", 32'(err1), 32'd0);

        // Start re-pulsed during DRAIN is ignored; reset at emission 5 releases all columns at once.
        step();
        drain1("restart", 5, -1, 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_arn", 32'(arn1), 32'hF);
        chk("async_rst_busy", 32'(busy1), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("post_rst_arn", 32'(arn1), 32'hF);
        drain1("after_rst", 16, -1, -1);
        wait_done1("after_rst", 4);

        // Protocol error: accept with nothing outstanding right after reset.
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        step();
        chk("perr_before", 32'(err1), 32'd0);
        acc1 = 1'b1;
        step();
        acc1 = 1'b0;
        chk("perr_set", 32'(err1), 32'd1);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk("perr_start_arn", 32'(arn1), 32'(col_mask(0)));
        chk("perr_sticky", 32'(err1), 32'd1);
        step();
        chk("perr_sticky2", 32'(err1), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
